multicycle_control: RTL and testbench

//  Moore/Mealy main sequencer for a multicycle MIPS datapath sharing one memory port and one ALU.

---
 rtl/multicycle_control_pkg.sv | 150 +++++++++++++++
 rtl/multicycle_control_mem_wait_timer.sv | 34 +++
 rtl/multicycle_control.sv | 113 +++++++++++
 tb/tb_multicycle_control.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS main sequencer.
// Holds the opcode constants, the ALUOp / ALUSrcB / PCSource encodings (the
// ALUOp codes are the same ones ALU_Control consumes), the state encoding, the
// registered control-word layout, and the opcode-decode helpers.
// Configuration: when MULTICYCLE_JUMP_EN is defined, opcode 000010 decodes to
// the JUMP state; otherwise it is an illegal opcode.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JUMP  = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC_B_REG     = 2'b00,
        SRC_B_FOUR    = 2'b01,
        SRC_B_IMM     = 2'b10,
        SRC_B_IMM_SH2 = 2'b11
    } src_b_t;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'b00,
        PC_SRC_ALUOUT = 2'b01,
        PC_SRC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_EXECUTE, S_ALU_WB, S_BRANCH, S_IMM_EXEC, S_IMM_WB,
        S_JUMP, S_ERROR
    } state_t;

    // Moore part of the control word; registered in the sequencer.
    typedef struct packed {
        logic    pc_write;
        logic    pc_write_cond;
        pc_src_t pc_source;
        logic    i_or_d;
        logic    mem_read;
        logic    mem_write;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    reg_write;
        logic    alu_src_a;
        src_b_t  alu_src_b;
        alu_op_t alu_op;
        logic    instr_done;
        logic    halted;
    } ctrl_t;

    // State that follows DECODE; S_FETCH marks an unsupported opcode.
    function automatic state_t decode_target(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:             return S_MEM_ADDR;
            OP_RTYPE:                 return S_EXECUTE;
            OP_BEQ:                   return S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: return S_IMM_EXEC;
`ifdef MULTICYCLE_JUMP_EN
            OP_JUMP:                  return S_JUMP;
`endif
            default:                  return S_FETCH;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return decode_target(op) != S_FETCH;
    endfunction

    // Control word asserted while sitting in state s (opcode picks the
    // immediate ALU operation).
    function automatic ctrl_t state_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_ADD;
            end
            // Speculatively form the branch target into ALUOut.
            S_DECODE:    c.alu_src_b = SRC_B_IMM_SH2;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            S_IMM_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = (op == OP_ANDI) ? ALU_AND :
                              (op == OP_ORI)  ? ALU_OR  : ALU_ADD;
            end
            S_IMM_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PC_SRC_JUMP;
                c.instr_done = 1'b1;
            end
`endif
            S_ERROR:     c.halted = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting on the memory handshake.
// Ports:
//   clk, rst (async, active-high)
//   clear    - zero the count (asserted on entry to a memory-wait state)
//   enable   - count this cycle (waiting and mem_ready low)
//   expired  - current cycle is the TIMEOUT_CYCLES-th wait cycle
// TIMEOUT_CYCLES = 0 disables expiry.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    // count holds the number of earlier wait cycles, so count == N-1 means
    // this is the N-th one.
    assign expired = (TIMEOUT_CYCLES != 0) && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencer for a multicycle MIPS datapath with one
// shared memory port and one ALU. Walks FETCH/DECODE/EXEC/MEM/WB, stalls on
// mem_ready, and falls into a halted ERROR state if a memory access exceeds
// TIMEOUT_CYCLES wait cycles (0 disables the timeout).
// Ports:
//   clk, rst (async, active-high), opcode (IR[31:26]), mem_ready
//   PC:     pc_write, pc_write_cond, pc_source
//   Memory: i_or_d, mem_read, mem_write, ir_write
//   RegFile: reg_dst, mem_to_reg, reg_write
//   ALU:    alu_src_a, alu_src_b, alu_op
//   Status: instr_done, illegal_instr, halted
// Configuration: define MULTICYCLE_JUMP_EN to support j (opcode 000010).
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       halted
);

    state_t state, next_state, wait_next;
    ctrl_t  ctrl_q;
    logic   in_wait, timer_clear, timer_expired, fetch_done;

    assign in_wait     = state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
    assign timer_clear = (next_state inside {S_FETCH, S_MEM_READ, S_MEM_WRITE})
                         && (next_state != state);

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (in_wait && !mem_ready),
        .expired (timer_expired)
    );

    // Where a stalled memory state goes if mem_ready stays low; a ready
    // handshake always takes precedence over an expiring timer.
    assign wait_next = timer_expired ? S_ERROR : state;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:     next_state = S_FETCH;
            S_FETCH:     next_state = mem_ready ? S_DECODE : wait_next;
            S_DECODE:    next_state = decode_target(opcode);
            S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : wait_next;
            S_MEM_WRITE: next_state = mem_ready ? S_FETCH : wait_next;
            S_EXECUTE:   next_state = S_ALU_WB;
            S_IMM_EXEC:  next_state = S_IMM_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_IMM_WB, S_JUMP:
                         next_state = S_FETCH;
            S_ERROR:     next_state = S_ERROR;
            default:     next_state = S_ERROR;
        endcase
    end

    // The Moore control word is registered alongside the state: it is
    // computed from next_state so it is valid in the cycle the state is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_RESET;
            ctrl_q <= '0;
        end else begin
            state  <= next_state;
            ctrl_q <= state_ctrl(next_state, opcode);
        end
    end

    // Mealy terms: the handshake completing this cycle commits the fetch or
    // finishes a store; opcode is only valid once IR is loaded (DECODE).
    assign fetch_done    = (state == S_FETCH) && mem_ready;
    assign ir_write      = fetch_done;
    assign pc_write      = ctrl_q.pc_write | fetch_done;
    assign instr_done    = ctrl_q.instr_done | ((state == S_MEM_WRITE) && mem_ready);
    assign illegal_instr = (state == S_DECODE) && !is_legal(opcode);

    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_source     = ctrl_q.pc_source;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign halted        = ctrl_q.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// from its opcode class into the expected per-cycle control vector, with
// random memory stalls; outputs are compared on the falling edge.
module tb_multicycle_control;

    localparam int TO = 4;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_IMM = 4, C_J = 5, C_ILL = 6;
    localparam int K_FETCH = 0, K_READ = 1, K_WRITE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_instr, halted;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;

    multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_instr(illegal_instr), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal_instr;
        logic       halted;
    } obs_t;

    obs_t obs;
    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_op, instr_done, illegal_instr, halted};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_class(input logic [5:0] o);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BEQ;
            6'b001000, 6'b001100, 6'b001101: return C_IMM;
`ifdef MULTICYCLE_JUMP_EN
            6'b000010: return C_J;
`endif
            default:   return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_op(input logic [5:0] o);
        if (o == 6'b001100) return 3'b011;
        if (o == 6'b001101) return 3'b100;
        return 3'b000;
    endfunction

    function automatic obs_t mem_e(input int kind, input logic rdy);
        obs_t e = '0;
        case (kind)
            K_FETCH: begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                e.ir_write = rdy;  e.pc_write  = rdy;
            end
            K_READ:  begin e.mem_read  = 1'b1; e.i_or_d = 1'b1; end
            default: begin e.mem_write = 1'b1; e.i_or_d = 1'b1; e.instr_done = rdy; end
        endcase
        return e;
    endfunction

    function automatic obs_t alu_e(input logic a, input logic [1:0] b, input logic [2:0] op);
        obs_t e = '0;
        e.alu_src_a = a; e.alu_src_b = b; e.alu_op = op;
        return e;
    endfunction

    function automatic obs_t wb_e(input logic dst, input logic m2r);
        obs_t e = '0;
        e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r; e.instr_done = 1'b1;
        return e;
    endfunction

    function automatic obs_t halt_e();
        obs_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Entered just after a rising edge; checks on the falling edge.
    task automatic tick(input string tag, input obs_t want);
        @(negedge clk);
        check(tag, obs, want);
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input string tag, input int kind, input int stalls,
                             input logic [5:0] opc, output bit timed_out);
        for (int i = 0; i < stalls && i < TO; i++) begin
            mem_ready = 1'b0;
            if (kind == K_FETCH) opcode = 6'($urandom);
            tick({tag, "_stall"}, mem_e(kind, 1'b0));
        end
        timed_out = (stalls >= TO);
        if (!timed_out) begin
            mem_ready = 1'b1;
            if (kind == K_FETCH) opcode = opc;
            tick(tag, mem_e(kind, 1'b1));
        end
    endtask

    task automatic run_instr(input logic [5:0] opc, input int f_stalls, input int m_stalls,
                             output bit err);
        int   c;
        bit   to;
        obs_t e;
        c   = op_class(opc);
        err = 1'b0;
        mem_phase("fetch", K_FETCH, f_stalls, opc, to);
        if (to) begin err = 1'b1; return; end
        mem_ready = 1'($urandom);
        e = alu_e(1'b0, 2'b11, 3'b000);
        e.illegal_instr = (c == C_ILL);
        tick("decode", e);
        mem_ready = 1'($urandom);
        case (c)
            C_LW: begin
                tick("lw_addr", alu_e(1'b1, 2'b10, 3'b000));
                mem_phase("lw_read", K_READ, m_stalls, opc, to);
                if (to) begin err = 1'b1; return; end
                mem_ready = 1'($urandom);
                tick("lw_wb", wb_e(1'b0, 1'b1));
            end
            C_SW: begin
                tick("sw_addr", alu_e(1'b1, 2'b10, 3'b000));
                mem_phase("sw_write", K_WRITE, m_stalls, opc, to);
                if (to) begin err = 1'b1; return; end
            end
            C_R: begin
                tick("r_exec", alu_e(1'b1, 2'b00, 3'b010));
                mem_ready = 1'($urandom);
                tick("r_wb", wb_e(1'b1, 1'b0));
            end
            C_BEQ: begin
                e = alu_e(1'b1, 2'b00, 3'b001);
                e.pc_write_cond = 1'b1; e.pc_source = 2'b01; e.instr_done = 1'b1;
                tick("beq", e);
            end
            C_IMM: begin
                tick("imm_exec", alu_e(1'b1, 2'b10, imm_op(opc)));
                mem_ready = 1'($urandom);
                tick("imm_wb", wb_e(1'b0, 1'b0));
            end
            C_J: begin
                e = '0;
                e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
                tick("jump", e);
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_async_zero", obs, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick("reset_state", '0);
    endtask

    task automatic expect_no_err(input string tag, input bit err);
        check(tag, 20'(err), 20'd0);
    endtask

    task automatic halt_then_reset();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            opcode    = 6'($urandom);
            tick("error_halted", halt_e());
        end
        do_reset();
    endtask

    logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                  6'b001000, 6'b001100, 6'b001101, 6'b000010};

    initial begin
        bit err;
        logic [5:0] op;
        #1;
        do_reset();

        // Directed: one of each class with an ideal memory.
        run_instr(6'b100011, 0, 0, err); expect_no_err("lw_err", err);
        run_instr(6'b000000, 0, 0, err); expect_no_err("r_err", err);
        run_instr(6'b000100, 0, 0, err); expect_no_err("beq_err", err);
        run_instr(6'b101011, 3, 0, err); expect_no_err("sw_fetch_stall_err", err);
        run_instr(6'b001000, 0, 0, err); expect_no_err("addi_err", err);
        run_instr(6'b001100, 0, 0, err); expect_no_err("andi_err", err);
        run_instr(6'b001101, 0, 0, err); expect_no_err("ori_err", err);
        run_instr(6'b111111, 0, 0, err); expect_no_err("illegal_err", err);
        run_instr(6'b000010, 0, 0, err); expect_no_err("jump_err", err);

        // Boundary: longest stall that must not time out, in every wait state.
        run_instr(6'b100011, TO - 1, TO - 1, err); expect_no_err("lw_max_stall", err);
        run_instr(6'b101011, TO - 1, TO - 1, err); expect_no_err("sw_max_stall", err);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom);
            run_instr(op, ($urandom_range(0, 1) == 1) ? $urandom_range(0, TO - 1) : 0,
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, TO - 1) : 0, err);
            expect_no_err("rand_err", err);
        end

        // Store whose memory never answers: ERROR after TO wait cycles.
        run_instr(6'b101011, 0, TO + 5, err);
        check("sw_timeout_flag", 20'(err), 20'd1);
        halt_then_reset();

        // Fetch that never answers.
        run_instr(6'b000000, TO, 0, err);
        check("fetch_timeout_flag", 20'(err), 20'd1);
        halt_then_reset();

        // Reset in MEM_WRITE while memory is ready: the write must drop at once.
        mem_phase("fetch", K_FETCH, 0, 6'b101011, err);
        mem_ready = 1'b1;
        tick("decode", alu_e(1'b0, 2'b11, 3'b000));
        tick("sw_addr", alu_e(1'b1, 2'b10, 3'b000));
        do_reset();
        run_instr(6'b100011, 1, 2, err); expect_no_err("after_reset_err", err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
